// File: rtl/song_block_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// song_block_sequencer_pkg
// Shared definitions for the song sequencer and the block inspector that
// feeds it: FSM state encoding, bus widths, block geometry and default
// timing constants, plus a helper that maps a song number to its first block.
// No ports (package).
// ---------------------------------------------------------------------------
package song_block_sequencer_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int MAX_NOTES_PER_BLOCK = 4;
    localparam int BLOCK_IDX_W         = 9;
    localparam int NOTE_PTR_W          = 2;
    localparam int SONG_SEL_W          = 2;
    localparam int FREQ_W              = 16;
    localparam int SIZE_W              = 3;

    localparam int DEF_SONG_STRIDE     = 128;
    localparam int DEF_FETCH_LAT       = 2;
    localparam int DEF_NOTE_TICKS      = 8;

    // First block index of a song region
    function automatic logic [BLOCK_IDX_W-1:0] songBase(
        input logic [SONG_SEL_W-1:0] sel,
        input int                    stride
    );
        return BLOCK_IDX_W'(int'(sel) * stride);
    endfunction

endpackage

// File: rtl/song_block_sequencer_note_timer.sv
// ---------------------------------------------------------------------------
// song_block_sequencer_note_timer
// Counts beat ticks for the note currently sounding.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   i_clear     zero the count (wins over i_enable)
//   i_enable    count one tick this cycle
//   o_terminal  count has reached NOTE_TICKS-1
// ---------------------------------------------------------------------------
module song_block_sequencer_note_timer #(
    parameter int NOTE_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    // One extra bit of headroom keeps the width legal when NOTE_TICKS is 1
    localparam int CNT_W = $clog2(NOTE_TICKS + 1);

    logic [CNT_W-1:0] r_count;

    // Tick counter: clear has priority so the owner can restart a note on
    // the same cycle the terminal tick arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_terminal = (r_count == CNT_W'(NOTE_TICKS - 1));

endmodule

// File: rtl/song_block_sequencer.sv
// ---------------------------------------------------------------------------
// song_block_sequencer
// Steps through the blocks of a selected song, waits out the inspector ROM
// latency, captures up to four note frequencies plus the block size, and
// plays the notes one at a time for NOTE_TICKS beat ticks each.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   play                 pulse, start the selected song from IDLE/DONE
//   restart              pulse, restart the latched song (not in IDLE)
//   pause                level, freeze note timing and mute
//   song_sel [1:0]       song number, sampled on an accepted play
//   tick                 beat strobe
//   block_idx_out [8:0]  block index to the inspector
//   song_sel_out [1:0]   latched song to the inspector
//   f_in0..3 [15:0]      note frequencies from the inspector
//   block_size_in [2:0]  notes in block, 0 marks the end of the song
//   note_freq [15:0]     current note frequency (held when silent)
//   note_valid           note_freq is sounding
//   note_start           pulse on the first PLAY cycle of each note
//   busy                 high in FETCH/LOAD/PLAY
//   song_done            high in DONE
// ---------------------------------------------------------------------------
module song_block_sequencer
    import song_block_sequencer_pkg::*;
#(
    parameter int SONG_STRIDE = DEF_SONG_STRIDE,
    parameter int FETCH_LAT   = DEF_FETCH_LAT,
    parameter int NOTE_TICKS  = DEF_NOTE_TICKS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   play,
    input  logic                   restart,
    input  logic                   pause,
    input  logic [SONG_SEL_W-1:0]  song_sel,
    input  logic                   tick,
    output logic [BLOCK_IDX_W-1:0] block_idx_out,
    output logic [SONG_SEL_W-1:0]  song_sel_out,
    input  logic [FREQ_W-1:0]      f_in0,
    input  logic [FREQ_W-1:0]      f_in1,
    input  logic [FREQ_W-1:0]      f_in2,
    input  logic [FREQ_W-1:0]      f_in3,
    input  logic [SIZE_W-1:0]      block_size_in,
    output logic [FREQ_W-1:0]      note_freq,
    output logic                   note_valid,
    output logic                   note_start,
    output logic                   busy,
    output logic                   song_done
);

    localparam int WAIT_W = $clog2(FETCH_LAT + 1);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [BLOCK_IDX_W-1:0] r_blockIdx;
    logic [BLOCK_IDX_W-1:0] w_idxNext;
    logic [SONG_SEL_W-1:0]  r_song;
    logic [SONG_SEL_W-1:0]  w_songNext;
    logic [FREQ_W-1:0]      r_buf [MAX_NOTES_PER_BLOCK];
    logic [SIZE_W-1:0]      r_size;
    logic [NOTE_PTR_W-1:0]  r_ptr;
    logic [FREQ_W-1:0]      r_heldFreq;
    logic                   r_newNote;
    logic [WAIT_W-1:0]      r_waitCnt;

    logic                   w_waitClear;
    logic                   w_capture;
    logic                   w_ptrInc;
    logic                   w_ptrClear;
    logic                   w_timerClear;
    logic                   w_timerEn;
    logic                   w_terminal;
    logic                   w_sizeBad;
    logic                   w_moreNotes;
    logic [BLOCK_IDX_W-1:0] w_songBase;
    logic [BLOCK_IDX_W-1:0] w_lastIdx;

    assign w_songBase  = songBase(r_song, SONG_STRIDE);
    assign w_lastIdx   = w_songBase + BLOCK_IDX_W'(SONG_STRIDE - 1);
    assign w_sizeBad   = (block_size_in == '0) ||
                         (block_size_in > SIZE_W'(MAX_NOTES_PER_BLOCK));
    assign w_moreNotes = ((SIZE_W'(r_ptr) + SIZE_W'(1)) < r_size);

    song_block_sequencer_note_timer #(
        .NOTE_TICKS (NOTE_TICKS)
    ) u_noteTimer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_timerClear),
        .i_enable   (w_timerEn),
        .o_terminal (w_terminal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control strobes. Restart is handled ahead of the case
    // because it behaves the same in every non-IDLE state and must beat play,
    // pause and tick. The last block of a region ends the song instead of
    // incrementing, which keeps the index inside 0..511.
    always_comb begin
        w_nextState  = r_state;
        w_idxNext    = r_blockIdx;
        w_songNext   = r_song;
        w_waitClear  = 1'b0;
        w_capture    = 1'b0;
        w_ptrInc     = 1'b0;
        w_ptrClear   = 1'b0;
        w_timerClear = 1'b0;
        w_timerEn    = 1'b0;

        if (restart && (r_state != ST_IDLE)) begin
            w_idxNext   = w_songBase;
            w_waitClear = 1'b1;
            w_nextState = ST_FETCH;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (play) begin
                        w_songNext  = song_sel;
                        w_idxNext   = songBase(song_sel, SONG_STRIDE);
                        w_waitClear = 1'b1;
                        w_nextState = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (r_waitCnt == WAIT_W'(FETCH_LAT - 1)) begin
                        w_nextState = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    w_capture = 1'b1;
                    if (w_sizeBad) begin
                        w_nextState = ST_DONE;
                    end else begin
                        w_ptrClear   = 1'b1;
                        w_timerClear = 1'b1;
                        w_nextState  = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick && !pause) begin
                        w_timerEn = 1'b1;
                        if (w_terminal) begin
                            w_timerClear = 1'b1;
                            if (w_moreNotes) begin
                                w_ptrInc = 1'b1;
                            end else if (r_blockIdx == w_lastIdx) begin
                                w_nextState = ST_DONE;
                            end else begin
                                w_idxNext   = r_blockIdx + BLOCK_IDX_W'(1);
                                w_waitClear = 1'b1;
                                w_nextState = ST_FETCH;
                            end
                        end
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: index and song latch, ROM wait counter, note buffer, pointer,
    // the held frequency shown while silent, and the new-note flag that
    // drives note_start for exactly one PLAY cycle per note.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blockIdx <= '0;
            r_song     <= '0;
            r_waitCnt  <= '0;
            r_size     <= '0;
            r_ptr      <= '0;
            r_heldFreq <= '0;
            r_newNote  <= 1'b0;
            for (int i = 0; i < MAX_NOTES_PER_BLOCK; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_blockIdx <= w_idxNext;
            r_song     <= w_songNext;

            if (w_waitClear) begin
                r_waitCnt <= '0;
            end else if (r_state == ST_FETCH) begin
                r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end

            if (w_capture) begin
                r_buf[0] <= f_in0;
                r_buf[1] <= f_in1;
                r_buf[2] <= f_in2;
                r_buf[3] <= f_in3;
                r_size   <= block_size_in;
            end

            if (w_ptrClear) begin
                r_ptr <= '0;
            end else if (w_ptrInc) begin
                r_ptr <= r_ptr + NOTE_PTR_W'(1);
            end

            if (r_state == ST_PLAY) begin
                r_heldFreq <= r_buf[r_ptr];
            end

            if (w_ptrClear || w_ptrInc) begin
                r_newNote <= 1'b1;
            end else if (r_state == ST_PLAY) begin
                r_newNote <= 1'b0;
            end
        end
    end

    assign block_idx_out = r_blockIdx;
    assign song_sel_out  = r_song;
    assign note_freq     = (r_state == ST_PLAY) ? r_buf[r_ptr] : r_heldFreq;
    assign note_valid    = (r_state == ST_PLAY) && !pause;
    assign note_start    = (r_state == ST_PLAY) && r_newNote;
    assign busy          = (r_state == ST_FETCH) || (r_state == ST_LOAD) ||
                           (r_state == ST_PLAY);
    assign song_done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_song_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_song_block_sequencer
// Directed bench for song_block_sequencer with a two-stage inspector ROM model.
// ---------------------------------------------------------------------------
module tb_song_block_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play = 1'b0;
    logic        restart = 1'b0;
    logic        pause = 1'b0;
    logic        tick = 1'b0;
    logic [1:0]  song_sel = 2'd0;
    logic [8:0]  block_idx_out;
    logic [1:0]  song_sel_out;
    logic [15:0] f_in0, f_in1, f_in2, f_in3;
    logic [2:0]  block_size_in;
    logic [15:0] note_freq;
    logic        note_valid;
    logic        note_start;
    logic        busy;
    logic        song_done;

    int checks = 0;
    int errors = 0;
    int romMode = 0;
    int startCount = 0;
    logic [8:0] romStage1 = '0;

    song_block_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .play          (play),
        .restart       (restart),
        .pause         (pause),
        .song_sel      (song_sel),
        .tick          (tick),
        .block_idx_out (block_idx_out),
        .song_sel_out  (song_sel_out),
        .f_in0         (f_in0),
        .f_in1         (f_in1),
        .f_in2         (f_in2),
        .f_in3         (f_in3),
        .block_size_in (block_size_in),
        .note_freq     (note_freq),
        .note_valid    (note_valid),
        .note_start    (note_start),
        .busy          (busy),
        .song_done     (song_done)
    );

    always #5 clk = ~clk;

    // Inspector content: mode 0/1 song 1 layouts, mode 2 full song 0
    function automatic logic [2:0] romSize(input int mode, input logic [8:0] idx);
        if (mode == 2) return (idx < 9'd128) ? 3'd4 : 3'd0;
        if (idx == 9'd128) return 3'd3;
        if (mode == 1 && idx == 9'd129) return 3'd1;
        if (mode == 1 && idx == 9'd130) return 3'd2;
        if (mode == 1 && idx == 9'd256) return 3'd1;
        return 3'd0;
    endfunction

    function automatic logic [15:0] romFreq(input int mode, input logic [8:0] idx, input int k);
        if (mode == 2) return 16'(100 + int'(idx) * 4 + k);
        case (idx)
            9'd128:  return (k == 0) ? 16'd440 : (k == 1) ? 16'd494 : (k == 2) ? 16'd523 : 16'd0;
            9'd129:  return (k == 0) ? 16'd600 : 16'd0;
            9'd130:  return (k == 0) ? 16'd700 : (k == 1) ? 16'd710 : 16'd0;
            9'd256:  return (k == 0) ? 16'd900 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    // Two register stages between index and data
    always @(posedge clk) begin
        romStage1     <= block_idx_out;
        block_size_in <= romSize(romMode, romStage1);
        f_in0         <= romFreq(romMode, romStage1, 0);
        f_in1         <= romFreq(romMode, romStage1, 1);
        f_in2         <= romFreq(romMode, romStage1, 2);
        f_in3         <= romFreq(romMode, romStage1, 3);
    end

    always @(posedge clk) begin
        if (note_start) startCount++;
    end

    // Hard stop if something never returns
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each tick: one idle cycle then one strobe cycle; returns in the cycle
    // right after the last strobe was consumed
    task automatic applyTicks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic pulsePlay(input logic [1:0] sel);
        song_sel = sel;
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
    endtask

    task automatic waitForPlay(input string name);
        int n = 0;
        while (!note_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (note_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: got note_valid %0b expected 1", name, note_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        checks++;
        if ({block_idx_out, song_sel_out, note_freq, note_valid, note_start, busy, song_done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got idx %0d busy %0b done %0b expected all 0",
                     block_idx_out, busy, song_done);
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if (busy !== 1'b0 || block_idx_out !== 9'd0) begin
            errors++;
            $display("[TB] FAIL restart_in_idle: got busy %0b idx %0d expected 0 0", busy, block_idx_out);
        end
    endtask

    task automatic test_play_block();
        int base;
        logic [15:0] exp [3];
        exp[0] = 16'd440; exp[1] = 16'd494; exp[2] = 16'd523;
        romMode = 0;
        pulsePlay(2'd1);
        checks++;
        if (block_idx_out !== 9'd128 || busy !== 1'b1 || note_valid !== 1'b0 || song_sel_out !== 2'd1) begin
            errors++;
            $display("[TB] FAIL fetch_start: got idx %0d busy %0b valid %0b expected 128 1 0",
                     block_idx_out, busy, note_valid);
        end
        cycles(1);
        checks++;
        if (block_idx_out !== 9'd128 || note_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_hold: got idx %0d valid %0b expected 128 0", block_idx_out, note_valid);
        end
        cycles(1);
        checks++;
        if (note_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_silent: got valid %0b busy %0b expected 0 1", note_valid, busy);
        end
        cycles(1);
        base = startCount;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (note_freq !== exp[k] || note_valid !== 1'b1 || note_start !== 1'b1) begin
                errors++;
                $display("[TB] FAIL note%0d_start: got freq %0d valid %0b start %0b expected %0d 1 1",
                         k, note_freq, note_valid, note_start, exp[k]);
            end
            applyTicks(7);
            checks++;
            if (note_freq !== exp[k] || note_start !== 1'b0) begin
                errors++;
                $display("[TB] FAIL note%0d_hold: got freq %0d start %0b expected %0d 0",
                         k, note_freq, note_start, exp[k]);
            end
            applyTicks(1);
        end
        checks++;
        if (block_idx_out !== 9'd129 || note_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL next_block: got idx %0d valid %0b expected 129 0", block_idx_out, note_valid);
        end
        checks++;
        if (startCount - base !== 3) begin
            errors++;
            $display("[TB] FAIL start_count: got %0d expected 3", startCount - base);
        end
    endtask

    task automatic test_end_of_song();
        cycles(3);
        checks++;
        if (song_done !== 1'b1 || busy !== 1'b0 || note_valid !== 1'b0 || block_idx_out !== 9'd129) begin
            errors++;
            $display("[TB] FAIL size0_done: got done %0b busy %0b valid %0b idx %0d expected 1 0 0 129",
                     song_done, busy, note_valid, block_idx_out);
        end
        checks++;
        if (note_freq !== 16'd523) begin
            errors++;
            $display("[TB] FAIL held_freq: got %0d expected 523", note_freq);
        end
        pulsePlay(2'd1);
        checks++;
        if (block_idx_out !== 9'd128 || song_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL replay: got idx %0d done %0b expected 128 0", block_idx_out, song_done);
        end
    endtask

    task automatic test_pause();
        int base;
        cycles(3);
        checks++;
        if (note_freq !== 16'd440 || note_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause_setup: got freq %0d start %0b expected 440 1", note_freq, note_start);
        end
        applyTicks(3);
        base = startCount;
        pause = 1'b1;
        #1;
        checks++;
        if (note_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pause_mute: got valid %0b expected 0", note_valid);
        end
        applyTicks(20);
        checks++;
        if (note_valid !== 1'b0 || note_freq !== 16'd440 || busy !== 1'b1 || block_idx_out !== 9'd128) begin
            errors++;
            $display("[TB] FAIL pause_hold: got valid %0b freq %0d expected 0 440", note_valid, note_freq);
        end
        pause = 1'b0;
        #1;
        checks++;
        if (note_valid !== 1'b1 || note_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pause_resume: got valid %0b start %0b expected 1 0", note_valid, note_start);
        end
        applyTicks(4);
        checks++;
        if (note_freq !== 16'd440 || startCount - base !== 0) begin
            errors++;
            $display("[TB] FAIL pause_remaining: got freq %0d starts %0d expected 440 0",
                     note_freq, startCount - base);
        end
        applyTicks(1);
        checks++;
        if (note_freq !== 16'd494 || note_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause_advance: got freq %0d start %0b expected 494 1", note_freq, note_start);
        end
    endtask

    task automatic test_restart();
        romMode = 1;
        applyTicks(16);
        waitForPlay("wait_129");
        checks++;
        if (block_idx_out !== 9'd129 || note_freq !== 16'd600) begin
            errors++;
            $display("[TB] FAIL block129: got idx %0d freq %0d expected 129 600", block_idx_out, note_freq);
        end
        applyTicks(8);
        waitForPlay("wait_130");
        checks++;
        if (block_idx_out !== 9'd130 || note_freq !== 16'd700) begin
            errors++;
            $display("[TB] FAIL block130: got idx %0d freq %0d expected 130 700", block_idx_out, note_freq);
        end
        pulsePlay(2'd3);
        checks++;
        if (block_idx_out !== 9'd130 || song_sel_out !== 2'd1 || note_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL play_ignored: got idx %0d song %0d expected 130 1", block_idx_out, song_sel_out);
        end
        applyTicks(2);
        song_sel = 2'd2;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if (block_idx_out !== 9'd128 || song_sel_out !== 2'd1 || busy !== 1'b1 || note_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_play: got idx %0d song %0d valid %0b expected 128 1 0",
                     block_idx_out, song_sel_out, note_valid);
        end
        waitForPlay("wait_replay");
        checks++;
        if (note_freq !== 16'd440 || block_idx_out !== 9'd128) begin
            errors++;
            $display("[TB] FAIL replay_first: got freq %0d idx %0d expected 440 128", note_freq, block_idx_out);
        end
    endtask

    task automatic test_region_end();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        romMode = 2;
        pulsePlay(2'd0);
        for (int b = 0; b < 128; b++) begin
            waitForPlay("wait_block");
            checks++;
            if (block_idx_out !== 9'(b) || note_freq !== romFreq(2, 9'(b), 0)) begin
                errors++;
                $display("[TB] FAIL region_block%0d: got idx %0d freq %0d expected %0d %0d",
                         b, block_idx_out, note_freq, b, romFreq(2, 9'(b), 0));
            end
            applyTicks(32);
        end
        checks++;
        if (song_done !== 1'b1 || busy !== 1'b0 || block_idx_out !== 9'd127) begin
            errors++;
            $display("[TB] FAIL region_done: got done %0b idx %0d expected 1 127", song_done, block_idx_out);
        end
        cycles(4);
        checks++;
        if (block_idx_out !== 9'd127 || song_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL region_stay: got idx %0d expected 127", block_idx_out);
        end
        song_sel = 2'd3;
        play = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        play = 1'b0;
        restart = 1'b0;
        checks++;
        if (block_idx_out !== 9'd0 || song_sel_out !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_beats_play: got idx %0d song %0d expected 0 0",
                     block_idx_out, song_sel_out);
        end
    endtask

    task automatic test_reset_mid_play();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        romMode = 1;
        pulsePlay(2'd2);
        waitForPlay("wait_256");
        checks++;
        if (block_idx_out !== 9'd256 || note_freq !== 16'd900 || song_sel_out !== 2'd2) begin
            errors++;
            $display("[TB] FAIL song2_play: got idx %0d freq %0d expected 256 900", block_idx_out, note_freq);
        end
        applyTicks(2);
        rst = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick = 1'b0;
        checks++;
        if ({block_idx_out, song_sel_out, note_freq, note_valid, note_start, busy, song_done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_play: got idx %0d freq %0d valid %0b busy %0b expected all 0",
                     block_idx_out, note_freq, note_valid, busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_play_block();
        test_end_of_song();
        test_pause();
        test_restart();
        test_region_end();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
